// File: rtl/dino_sprite_ctrl.sv
// Dino sprite controller: animation state machine plus a 3-stage beam-to-pixel
// pipeline that addresses the sprite ROM and serialises the returned row.
module dino_sprite_ctrl #(
  parameter int ANIM_TICKS = 6,
  parameter int SPR_W      = 22,
  parameter int SPR_H      = 47
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             frame_tick,
  input  logic             game_run,
  input  logic             airborne,
  input  logic             game_over,
  input  logic [9:0]       h_cnt,
  input  logic [9:0]       v_cnt,
  input  logic [9:0]       dino_x,
  input  logic [9:0]       dino_y,
  input  logic [SPR_W-1:0] rom_data,
  output logic [11:0]      addr_dino,
  output logic             pixel_on,
  output logic             frame_sel,
  output logic [2:0]       anim_state
);

  localparam int CNT_W = (ANIM_TICKS > 1) ? $clog2(ANIM_TICKS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ANIM_TICKS - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN_A = 3'd1,
    S_RUN_B = 3'd2,
    S_AIR   = 3'd3,
    S_DEAD  = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             frame_q, frame_d;

  logic [10:0]      x_end_s, y_end_s;
  logic [4:0]       col0_s;
  logic [5:0]       row0_s;
  logic             in_box_s;

  logic [11:0]      addr_q, addr_d;
  logic [4:0]       col1_q, col1_d;
  logic             v1_q, v1_d;
  logic [4:0]       col2_q, col2_d;
  logic             v2_q, v2_d;
  logic             pix_q, pix_d;
  logic [31:0]      rom_ext_s;
  logic [4:0]       bit_idx_s;

  // Animation next-state: only evaluated on a frame tick, priority dead > air > idle > run.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (frame_tick) begin
      if (game_over) begin
        state_d = S_DEAD;
        cnt_d   = '0;
      end else if (airborne) begin
        state_d = S_AIR;
        cnt_d   = '0;
      end else if (!game_run) begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end else begin
        case (state_q)
          S_RUN_A: begin
            if (cnt_q == CNT_LAST) begin
              state_d = S_RUN_B;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
          S_RUN_B: begin
            if (cnt_q == CNT_LAST) begin
              state_d = S_RUN_A;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
          default: begin
            state_d = S_RUN_A;
            cnt_d   = '0;
          end
        endcase
      end
    end else begin
      state_d = state_q;
      cnt_d   = cnt_q;
    end
    frame_d = (state_d == S_RUN_B);
  end

  // Animation state, tick counter and frame select registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      frame_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      frame_q <= frame_d;
    end
  end

  // Stage 0: bounding box in 11 bits so sprites near the screen edge clip instead of wrapping.
  always_comb begin
    x_end_s  = {1'b0, dino_x} + 11'(SPR_W);
    y_end_s  = {1'b0, dino_y} + 11'(SPR_H);
    col0_s   = h_cnt[4:0] - dino_x[4:0];
    row0_s   = v_cnt[5:0] - dino_y[5:0];
    in_box_s = (h_cnt >= dino_x) && ({1'b0, h_cnt} < x_end_s) &&
               (v_cnt >= dino_y) && ({1'b0, v_cnt} < y_end_s);
  end

  // Stages 1-3 next values; the bit select is widened so off-box columns never index out of range.
  always_comb begin
    if (in_box_s) begin
      addr_d = {3'b000, frame_q, 2'b00, row0_s};
    end else begin
      addr_d = 12'h000;
    end
    col1_d    = col0_s;
    v1_d      = in_box_s;
    col2_d    = col1_q;
    v2_d      = v1_q;
    rom_ext_s = 32'(rom_data);
    bit_idx_s = 5'(SPR_W - 1) - col2_q;
    pix_d     = v2_q & rom_ext_s[bit_idx_s];
  end

  // Pixel pipeline registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= 12'h000;
      col1_q <= 5'd0;
      v1_q   <= 1'b0;
      col2_q <= 5'd0;
      v2_q   <= 1'b0;
      pix_q  <= 1'b0;
    end else begin
      addr_q <= addr_d;
      col1_q <= col1_d;
      v1_q   <= v1_d;
      col2_q <= col2_d;
      v2_q   <= v2_d;
      pix_q  <= pix_d;
    end
  end

  assign addr_dino  = addr_q;
  assign pixel_on   = pix_q;
  assign frame_sel  = frame_q;
  assign anim_state = state_q;

endmodule

// File: tb/tb_dino_sprite_ctrl.sv
// Self-checking bench for dino_sprite_ctrl: directed scenarios plus random
// stimulus compared every cycle against an abstract animation/pixel model.
module tb_dino_sprite_ctrl;

  localparam int ANIM = 6;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        frame_tick = 1'b0;
  logic        game_run = 1'b0;
  logic        airborne = 1'b0;
  logic        game_over = 1'b0;
  logic [9:0]  h_cnt = 10'd0;
  logic [9:0]  v_cnt = 10'd0;
  logic [9:0]  dino_x = 10'd0;
  logic [9:0]  dino_y = 10'd0;
  logic [21:0] rom_data = 22'd0;
  logic [11:0] addr_dino;
  logic        pixel_on;
  logic        frame_sel;
  logic [2:0]  anim_state;

  logic [21:0] rom_mem [4096];
  int          n_checks = 0;
  int          n_fail = 0;
  int          ms = 0;
  int          mc = 0;
  bit          pq[$];

  dino_sprite_ctrl #(.ANIM_TICKS(ANIM), .SPR_W(22), .SPR_H(47)) dut (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .game_run(game_run),
    .airborne(airborne), .game_over(game_over), .h_cnt(h_cnt), .v_cnt(v_cnt),
    .dino_x(dino_x), .dino_y(dino_y), .rom_data(rom_data),
    .addr_dino(addr_dino), .pixel_on(pixel_on), .frame_sel(frame_sel),
    .anim_state(anim_state)
  );

  always #5 clk = ~clk;

  // Behavioural sprite ROM with one cycle of registered read latency.
  always @(posedge clk) rom_data <= rom_mem[addr_dino];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  // One pixel clock: predict from the current inputs, clock, advance the model, compare.
  task automatic step();
    int h, v, dx, dy, col;
    bit inbox, exp_p;
    int exp_a;
    logic [21:0] w;
    h = int'(h_cnt); v = int'(v_cnt); dx = int'(dino_x); dy = int'(dino_y);
    inbox = (h >= dx) && (h < dx + 22) && (v >= dy) && (v < dy + 47);
    exp_a = 0;
    exp_p = 1'b0;
    if (inbox) begin
      exp_a = ((ms == 2) ? 256 : 0) + ((v - dy) % 64);
      col   = h - dx;
      w     = rom_mem[exp_a];
      exp_p = w[21 - col];
    end
    pq.push_back(exp_p);
    @(posedge clk);
    #1;
    if (frame_tick) begin
      if (game_over) ms = 4;
      else if (airborne) ms = 3;
      else if (!game_run) ms = 0;
      else if (ms == 1 || ms == 2) begin
        mc++;
        if (mc == ANIM) begin
          ms = 3 - ms;
          mc = 0;
        end
      end else begin
        ms = 1;
        mc = 0;
      end
    end
    check_eq("state", 32'(anim_state), 32'(ms));
    check_eq("frame_sel", 32'(frame_sel), 32'(ms == 2));
    check_eq("addr", 32'(addr_dino), 32'(exp_a));
    check_eq("pixel", 32'(pixel_on), 32'(pq.pop_front()));
  endtask

  task automatic tick_step();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
  endtask

  task automatic beam(input int h, input int v);
    h_cnt = 10'(h);
    v_cnt = 10'(v);
    step();
  endtask

  task automatic rand_beam();
    h_cnt = 10'(int'(dino_x) + int'($urandom_range(0, 29)) - 4);
    v_cnt = 10'(int'(dino_y) + int'($urandom_range(0, 54)) - 4);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_state"}, 32'(anim_state), 32'd0);
    check_eq({tag, "_frame"}, 32'(frame_sel), 32'd0);
    check_eq({tag, "_addr"}, 32'(addr_dino), 32'd0);
    check_eq({tag, "_pixel"}, 32'(pixel_on), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) rom_mem[i] = 22'($urandom);
    rom_mem[0] = 22'h3FFFFF;
    pq = '{1'b0, 1'b0};

    #1 rst_n = 1'b0;
    #2 check_reset_outputs("por");
    #9 rst_n = 1'b1;

    // Run animation: 14 ticks with idle cycles in between.
    dino_x = 10'd100; dino_y = 10'd200; game_run = 1'b1;
    for (int t = 1; t <= 14; t++) begin
      for (int k = 0; k < 3; k++) begin
        rand_beam();
        step();
      end
      rand_beam();
      tick_step();
      if (t == 1) check_eq("tick1_run_a", 32'(anim_state), 32'd1);
      if (t == 7) check_eq("tick7_run_b", 32'(anim_state), 32'd2);
      if (t == 7) check_eq("tick7_frame", 32'(frame_sel), 32'd1);
      if (t == 13) check_eq("tick13_run_a", 32'(anim_state), 32'd1);
    end

    // Reach RUN_B, then check the frame-1 address.
    for (int t = 0; t < 20 && ms != 2; t++) tick_step();
    check_eq("reach_run_b", 32'(anim_state), 32'd2);
    beam(100, 202);
    check_eq("addr_run_b", 32'(addr_dino), 32'h102);
    beam(0, 0);

    // Asynchronous reset between ticks while in RUN_B.
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("mid_rst");
    ms = 0; mc = 0;
    pq = '{1'b0, 1'b0};
    #1 rst_n = 1'b1;
    game_run = 1'b0;

    // Pipeline and horizontal edges in frame 0.
    beam(100, 202);
    check_eq("addr_frame0", 32'(addr_dino), 32'h002);
    beam(0, 0);
    beam(121, 202);
    beam(122, 202);
    beam(99, 202);
    beam(0, 0);
    beam(0, 0);
    beam(0, 0);
    check_eq("pixel_h99_off", 32'(pixel_on), 32'd0);

    // Screen-edge clipping.
    dino_x = 10'd1010; dino_y = 10'd1000;
    beam(3, 3);
    check_eq("clip_no_wrap", 32'(addr_dino), 32'h000);
    beam(1023, 1020);
    check_eq("clip_edge_addr", 32'(addr_dino), 32'h014);
    beam(0, 0);
    beam(0, 0);
    beam(0, 0);

    // Jump and death priority.
    dino_x = 10'd100; dino_y = 10'd200; game_run = 1'b1;
    for (int t = 0; t < 20 && ms != 2; t++) tick_step();
    airborne = 1'b1;
    tick_step();
    check_eq("air_state", 32'(anim_state), 32'd3);
    check_eq("air_frame", 32'(frame_sel), 32'd0);
    airborne = 1'b0;
    tick_step();
    check_eq("land_run_a", 32'(anim_state), 32'd1);
    for (int t = 0; t < 5; t++) tick_step();
    check_eq("land_cnt_hold", 32'(anim_state), 32'd1);
    tick_step();
    check_eq("land_cnt_toggle", 32'(anim_state), 32'd2);
    game_over = 1'b1; airborne = 1'b1;
    tick_step();
    check_eq("dead_wins", 32'(anim_state), 32'd4);
    airborne = 1'b0;
    step();
    tick_step();
    check_eq("dead_sticky", 32'(anim_state), 32'd4);
    game_over = 1'b0;
    tick_step();
    check_eq("dead_exit", 32'(anim_state), 32'd1);

    // Randomised run against the model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        dino_x = 10'($urandom);
        dino_y = 10'($urandom);
      end
      frame_tick = ($urandom_range(0, 7) == 0);
      if (frame_tick) begin
        game_run  = ($urandom_range(0, 9) != 0);
        airborne  = ($urandom_range(0, 5) == 0);
        game_over = ($urandom_range(0, 11) == 0);
      end
      rand_beam();
      step();
    end
    frame_tick = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dino_sprite_ctrl.md
Name: dino_sprite_ctrl

Overview:
- Sequences the dino sprite ROM (12-bit address, 22-bit row word, 1-cycle registered read) for the VGA renderer.
- Runs the animation state machine: IDLE, RUN_A, RUN_B, AIR, DEAD. Selects frame 0 or 1 once per video frame.
- Generates the ROM row address from the current beam position and serialises the returned row into a per-pixel `pixel_on`.
- Sits between the game FSM/VGA timing generator and the colour mux.

Parameters:
- `ANIM_TICKS`, 6: number of `frame_tick` pulses between run-frame toggles (must be ≥1).
- `SPR_W`, 22: sprite width in pixels, equal to the ROM word width.
- `SPR_H`, 47: sprite height in rows (row indices 0x00–0x2E).

Ports:
- `clk`  in  1  pixel clock, one pixel per cycle.
- `rst_n`  in  1  asynchronous active-low reset.
- `frame_tick`  in  1  single-cycle pulse at start of vertical blanking.
- `game_run`  in  1  game running.
- `airborne`  in  1  dino off ground (jumping).
- `game_over`  in  1  collision/dead.
- `h_cnt`  in  10  current beam column.
- `v_cnt`  in  10  current beam row.
- `dino_x`  in  10  sprite top-left column.
- `dino_y`  in  10  sprite top-left row.
- `rom_data`  in  22  ROM row word; bit 21 = leftmost pixel.
- `addr_dino`  out  12  ROM address = {3'b000, frame_sel, 2'b00, row[5:0]}; frame 0 base 0x000, frame 1 base 0x100.
- `pixel_on`  out  1  sprite pixel opaque at the beam position 3 cycles earlier.
- `frame_sel`  out  1  current animation frame.
- `anim_state`  out  3  state encoding: IDLE=0, RUN_A=1, RUN_B=2, AIR=3, DEAD=4.

Behaviour:
- Reset (async, while `rst_n`=0):
  - `addr_dino`=12'h000, `pixel_on`=0, `frame_sel`=0, state IDLE.
  - Tick counter=0; all pipeline valid/column registers=0.
  - Takes effect immediately, including mid-line or mid-frame.
- Animation FSM evaluates only in cycles with `frame_tick`=1; it holds otherwise, so no frame change occurs mid-scan.
- Next-state priority at a tick:
  1. `game_over` → DEAD.
  2. Else `airborne` → AIR.
  3. Else `!game_run` → IDLE.
  4. Else if current state is IDLE/AIR → RUN_A with counter cleared.
  5. Else (RUN_A/RUN_B): counter increments. At counter==`ANIM_TICKS`-1, toggle RUN_A↔RUN_B and clear the counter.
- DEAD is sticky until `game_over`=0 at a tick; priority then re-applies.
- Frame select, registered with state: `frame_sel`=1 only in RUN_B; 0 in all other states.
- Stage 0 (combinational from inputs):
  - `hx = {1'b0,h_cnt} − {1'b0,dino_x}`, `vy` likewise; 11-bit arithmetic, no wrap.
  - `in_box = h_cnt>=dino_x && {1'b0,h_cnt} < dino_x+SPR_W && v_cnt>=dino_y && {1'b0,v_cnt} < dino_y+SPR_H`. Bounds sums are 11-bit, so sprites near column/row 1023 clip rather than wrap.
- Stage 1 (register):
  - `addr_dino` ← `in_box` ? {3'b000, frame_sel, 2'b00, vy[5:0]} : 12'h000.
  - `col1` ← hx[4:0]; `v1` ← `in_box`.
- Stage 2 (register): `col2` ← `col1`, `v2` ← `v1`; the ROM presents `rom_data` for the stage-1 address this cycle.
- Stage 3 (register): `pixel_on` ← `v2` & `rom_data[21−col2]`.
- Total latency from `h_cnt`/`v_cnt` to `pixel_on` is exactly 3 cycles; the renderer delays its other layers to match.
- `frame_sel` change on a tick affects the address from the next cycle. Ticks occur in blanking, so no visible tear.
- Out-of-box pixels always give `pixel_on`=0, regardless of `rom_data`.
- Simultaneous `frame_tick` with `game_over` and `airborne`: DEAD wins.

Test Plan:
- Reset mid-run: hold RUN_B, assert `rst_n`=0 between ticks → `anim_state`=0, `frame_sel`=0, `addr_dino`=0, `pixel_on`=0 without waiting for a clock edge.
- Run animation: `game_run`=1, `ANIM_TICKS`=6, 14 ticks.
  - Tick 1 → RUN_A.
  - After 6 further ticks → RUN_B, `frame_sel`=1.
  - After 6 more → RUN_A.
  - No state change on non-tick cycles.
- Jump and death priority:
  - `airborne`=1 at a tick in RUN_B → AIR, `frame_sel`=0.
  - `airborne`=0 at the next tick → RUN_A, counter=0.
  - `game_over`=`airborne`=1 on the same tick → DEAD.
- Address/pixel pipeline: `dino_x`=100, `dino_y`=200, frame 0, beam (h=100, v=202) → `addr_dino`=12'h002 one cycle later; `pixel_on` = bit 21 of the returned word three cycles later. In RUN_B → `addr_dino`=12'h102.
- Horizontal edges: h=121 → in box, col 21 selects bit 0. h=122 and h=99 → `pixel_on`=0 even with `rom_data`=all-ones.
- Screen-edge clipping: `dino_x`=1010, `dino_y`=1000, h=3, v=3 → no match (no wrap); h=1023, v=1020 → col 13, row 20, `addr_dino`=12'h014.
